// File: rtl/uart_tx.sv
// UART transmitter fed by a first-word-fall-through FIFO: one tx_fifo_rd pulse per frame; tx/tx_busy are registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx_fifo_rd,
  output logic            tx_busy,
  output logic            tx
);

  localparam int TMAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(DBIT + 1);

  localparam logic [TW-1:0] OS_LAST  = TW'(OS_TICK - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tick;
  logic [BW-1:0]   r_bit;
  logic [DBIT-1:0] r_shift;
  logic            r_tx;
  logic            r_busy;
  logic            r_rd;
`ifdef UART_TX_PARITY_EN
  logic            r_par;
`endif

  logic            w_os_done;
  logic            w_sb_done;
  logic [TW-1:0]   w_tick_inc;

  assign w_os_done  = s_tick && (r_tick == OS_LAST);
  assign w_sb_done  = s_tick && (r_tick == SB_LAST);
  assign w_tick_inc = r_tick + TW'(1);

  // r_tx is loaded one cycle ahead with the level of the state being entered,
  // so the line toggles exactly at state boundaries and never glitches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_rd    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_shift <= tx_din;
            r_tick  <= '0;
            r_bit   <= '0;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^tx_din;
`endif
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_os_done) begin
            r_tick  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else if (s_tick) begin
            r_tick <= w_tick_inc;
          end
        end
        S_DATA: begin
          if (w_os_done) begin
            r_tick  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + BW'(1);
              r_tx  <= r_shift[1];
            end
          end else if (s_tick) begin
            r_tick <= w_tick_inc;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_os_done) begin
            r_tick  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else if (s_tick) begin
            r_tick <= w_tick_inc;
          end
        end
`endif
        S_STOP: begin
          if (w_sb_done) begin
            r_tick  <= '0;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
            r_state <= S_IDLE;
          end else if (s_tick) begin
            r_tick <= w_tick_inc;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_fifo_rd = r_rd;
  assign tx_busy    = r_busy;
  assign tx         = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: fixed frame table, hand-written corner sequences, and random traffic against a frame-level model.
// Build with UART_TX_PARITY_EN defined to check the parity variant.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] tx_din;
  logic       tx_fifo_rd;
  logic       tx_busy;
  logic       tx;

  logic       st32;
  logic [7:0] din32;
  logic       rd32;
  logic       busy32;
  logic       tx32;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .OS_TICK(16)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .tx_din(tx_din),
    .tx_fifo_rd(tx_fifo_rd), .tx_busy(tx_busy), .tx(tx)
  );

  uart_tx #(.DBIT(8), .SB_TICK(32), .OS_TICK(16)) dut32 (
    .clk(clk), .reset(reset), .tx_start(st32), .s_tick(s_tick), .tx_din(din32),
    .tx_fifo_rd(rd32), .tx_busy(busy32), .tx(tx32)
  );

`ifdef UART_TX_PARITY_EN
  localparam int NPER = 11;
`else
  localparam int NPER = 10;
`endif
  localparam int FLEN = 16 * NPER;

  typedef struct {
    logic [7:0] din;
    logic [9:0] line;
    logic       par;
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  logic       cap[$];
  logic       cap32[$];
  logic       expq[$];
  logic       work[$];
  logic [7:0] fifo[$];
  int         rd_cnt = 0;
  int         rd32_cnt = 0;
  int         gap_cnt = 0;
  int         gap_base = 0;
  bit         model_on = 1'b0;
  int         tick_mod = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: start, 8 data bits LSB first, optional even parity, stop.
  task automatic push_frame(input logic [7:0] b);
    for (int k = 0; k < 16; k++) expq.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 16; k++) expq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    for (int k = 0; k < 16; k++) expq.push_back(^b);
`endif
    for (int k = 0; k < 16; k++) expq.push_back(1'b1);
  endtask

  // FWFT FIFO in front of the main DUT; tx_din is junk whenever it is empty.
  initial begin
    tx_start = 1'b0;
    tx_din   = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_fifo_rd === 1'b1) begin
        rd_cnt++;
        if (fifo.size() > 0) begin
          if (model_on) push_frame(fifo[0]);
          fifo.delete(0);
        end
      end
      tx_start = (fifo.size() > 0);
      tx_din   = (fifo.size() > 0) ? fifo[0] : 8'($urandom);
    end
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (tick_mod <= 1) ? 1'b1 : ($urandom_range(0, tick_mod - 1) == 0);
    end
  end

  always @(negedge clk) begin
    if (s_tick && tx_busy === 1'b1) cap.push_back(tx);
    if (s_tick && busy32 === 1'b1) cap32.push_back(tx32);
    if (rd32 === 1'b1) rd32_cnt++;
    if (tx_busy === 1'b0 && fifo.size() > 0 && rd_cnt != gap_base) gap_cnt++;
  end

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
    end while ((fifo.size() != 0 || tx_busy !== 1'b0 || busy32 !== 1'b0 || st32) && c < budget);
    if (c >= budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: still busy after %0d cycles", name, c);
    end
  endtask

  // Checks the tick-by-tick line level captured in work against a hand-written frame.
  task automatic check_line(input string name, input logic [9:0] line, input logic par, input int sb);
    int k;
    k = 0;
    chk({name, " ticks"}, work.size(), 16 * (NPER - 1) + sb);
    for (int p = 0; p < NPER; p++) begin
      logic e;
      logic v;
      int   len;
`ifdef UART_TX_PARITY_EN
      e = (p < 9) ? line[p] : ((p == 9) ? par : line[9]);
`else
      e = line[p];
`endif
      len = (p == NPER - 1) ? sb : 16;
      v = e;
      for (int j = 0; j < len; j++) begin
        if (k < work.size()) begin
          if (work[k] !== e) v = work[k];
        end else begin
          v = 1'bx;
        end
        k++;
      end
      chk($sformatf("%s bit%0d", name, p), {31'd0, v}, {31'd0, e});
    end
  endtask

  task automatic compare_streams(input string name);
    int bad;
    chk({name, " len"}, cap.size(), expq.size());
    for (int f = 0; f * FLEN < expq.size(); f++) begin
      bad = 0;
      for (int j = 0; j < FLEN; j++) begin
        if (f * FLEN + j >= cap.size()) bad++;
        else if (cap[f * FLEN + j] !== expq[f * FLEN + j]) bad++;
      end
      chk($sformatf("%s frame%0d", name, f), bad, 0);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   r0;
    int   c;
    tbl[0] = '{8'h55, 10'h2AA, 1'b0};
    tbl[1] = '{8'h07, 10'h20E, 1'b1};
    tbl[2] = '{8'hA3, 10'h346, 1'b0};
    tbl[3] = '{8'h00, 10'h200, 1'b0};
    tbl[4] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[5] = '{8'h80, 10'h300, 1'b1};
    tbl[6] = '{8'h01, 10'h202, 1'b1};

    reset = 1'b0;
    st32  = 1'b0;
    din32 = 8'h00;
    @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", tx_busy, 0);
    chk("reset rd", tx_fifo_rd, 0);
    chk("reset tx32", tx32, 1);
    chk("reset busy32", busy32, 0);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle tx", tx, 1);
    chk("idle busy", tx_busy, 0);

    for (int i = 0; i < 7; i++) begin
      tick_mod = (i % 2) + 1;
      cap.delete();
      r0 = rd_cnt;
      fifo.push_back(tbl[i].din);
      wait_idle(5000, $sformatf("vec%0d", i));
      work = cap;
      check_line($sformatf("vec%0d", i), tbl[i].line, tbl[i].par, 16);
      chk($sformatf("vec%0d rd pulses", i), rd_cnt - r0, 1);
    end

    // Back-to-back frames: only the one IDLE cycle separates them.
    tick_mod = 1;
    cap.delete();
    expq.delete();
    r0 = rd_cnt;
    gap_base = rd_cnt;
    gap_cnt = 0;
    repeat (3) fifo.push_back(8'h55);
    repeat (3) push_frame(8'h55);
    wait_idle(5000, "cont");
    compare_streams("cont");
    chk("cont rd pulses", rd_cnt - r0, 3);
    chk("cont idle gap cycles", gap_cnt, 2);

    // Reset in the middle of DATA, with the next byte already waiting.
    cap.delete();
    r0 = rd_cnt;
    fifo.push_back(8'h55);
    fifo.push_back(8'hC3);
    c = 0;
    while (cap.size() < 40 && c < 2000) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("midrst reached data", cap.size() >= 40, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst tx", tx, 1);
    chk("midrst busy", tx_busy, 0);
    chk("midrst rd", tx_fifo_rd, 0);
    #1;
    reset = 1'b1;
    cap.delete();
    wait_idle(5000, "midrst");
    work = cap;
    check_line("midrst next", 10'h386, 1'b0, 16);
    chk("midrst rd pulses", rd_cnt - r0, 2);

    // Two-stop-bit instance, single-cycle request, junk on tx_din afterwards.
    tick_mod = 2;
    cap32.delete();
    r0 = rd32_cnt;
    din32 = 8'hA3;
    st32 = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
    end while (rd32 !== 1'b1 && c < 100);
    chk("sb32 rd seen", rd32, 1);
    st32 = 1'b0;
    din32 = 8'h5C;
    wait_idle(10000, "sb32");
    work = cap32;
    check_line("sb32", 10'h346, 1'b0, 32);
    chk("sb32 rd pulses", rd32_cnt - r0, 1);

    // Random bytes, random request timing, random tick density.
    model_on = 1'b1;
    cap.delete();
    expq.delete();
    r0 = rd_cnt;
    for (int n = 0; n < 20; n++) begin
      tick_mod = $urandom_range(1, 3);
      fifo.push_back(8'($urandom));
      repeat ($urandom_range(0, 200)) @(negedge clk);
      #1;
    end
    wait_idle(40000, "rand");
    model_on = 1'b0;
    compare_streams("rand");
    chk("rand rd pulses", rd_cnt - r0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
